bf_fetch_sequencer: RTL and testbench
=====================================

// Module: bf_fetch_sequencer
// PURPOSE
//  Instruction sequencer for the brainfuck core. Owns the program counter and drives the
//  combinational program ROM address. Issues +,-,<,>,.,, to the execute unit over a
//  valid/ready handshake. Resolves [ and ] internally via cell_zero and bracket-matching scans.
// PARAMETERS
//  ADDR_W   10  ROM address / PC width
//  DEPTH_W  8   nesting-depth counter width (max depth 2**DEPTH_W-1)
// PORTS
//  clk          in   1       system clock (single clock domain)
//  rst          in   1       asynchronous, active-high reset
//  start        in   1       pulse: begin execution at address 0
//  rom_addr     out  ADDR_W  = pc register; ROM is combinational, code valid same cycle
//  rom_code     in   3       opcode at rom_addr (bf_pkg::opcode_t)
//  rom_overrun  in   1       rom_addr >= program length
//  instr_valid  out  1       instr_code valid for execute unit
//  instr_code   out  3       opcode issued (never IF/BACK)
//  instr_ready  in   1       execute unit accepts instr_code this cycle
//  exec_idle    in   1       execute unit has retired all accepted ops; cell_zero is valid
//  cell_zero    in   1       current data cell == 0
//  busy         out  1       state is RUN, SCAN_FWD or SCAN_BACK
//  done         out  1       program ran off end (state DONE)
//  err          out  2       0 none, 1 unmatched '[', 2 unmatched ']', 3 depth overflow
// BEHAVIOUR
//  Reset: pc=0, depth=0, state=IDLE; instr_valid=0, busy=0, done=0, err=0.
//  States: IDLE, RUN, SCAN_FWD, SCAN_BACK, DONE, ERROR.
//  IDLE / DONE / ERROR: start -> pc<=0, depth<=0, err<=0, RUN next cycle. Otherwise hold.
//    start is ignored while busy.
//  RUN, checked in priority order:
//   1 rom_overrun -> DONE; instr_valid=0.
//   2 rom_code in {INC,DEC,MOVR,MOVL,OUT,IN}:
//     instr_valid=1 and instr_code=rom_code, combinational from state and rom_code.
//     pc<=pc+1 only on valid&&ready. instr_code is held stable while ready=0.
//   3 rom_code==IF or BACK: evaluated only when exec_idle=1; else stall with valid=0.
//     Each bracket costs 1 cycle.
//     IF  && !cell_zero -> pc+1.
//     IF  &&  cell_zero -> SCAN_FWD, pc+1, depth<=1.
//     BACK&&  cell_zero -> pc+1.
//     BACK&& !cell_zero -> SCAN_BACK, pc-1, depth<=1.
//  SCAN_FWD, one address per cycle, valid=0:
//   - rom_overrun -> ERROR, err=1.
//   - IF -> depth+1. If depth is already all-ones -> ERROR, err=3.
//   - BACK with depth==1 -> RUN, pc<=pc+1 (first op after the matching ']').
//   - BACK with depth>1 -> depth-1.
//   - any other code -> skip. pc+1 on every non-exit cycle.
//  SCAN_BACK, pc decrements each cycle, valid=0:
//   - BACK -> depth+1, with the same overflow rule (err=3).
//   - IF with depth==1 -> RUN, pc<=pc+1 (first op after the matching '[').
//   - IF with depth>1 -> depth-1.
//   - pc==0 without a terminating match -> ERROR, err=2; pc never wraps.
//  Arithmetic: pc and depth are unsigned, no wrap. Overflow is reported via err, never silent.
//  done is high only in DONE. err holds until next start or rst.
//  rst mid-operation (any state, incl. mid-handshake or mid-scan) -> immediate reset values.
//  Execute unit must discard any unaccepted op.
// STRUCTURE
//  bf_pkg holds:
//   - opcode_t enum: INC=3'b111, DEC=3'b110, MOVR=3'b101, MOVL=3'b100, IF=3'b011,
//     BACK=3'b010, OUT=3'b001, IN=3'b000; shared with ROM and execute unit.
//   - seq_state_t enum.
//   - err_t codes: ERR_NONE, ERR_OPEN, ERR_CLOSE, ERR_DEPTH.
//  Single module; scan logic is small enough to stay inline. No sub-module.
// TESTING
//  Bench uses a stub ROM (array + length) plus a scripted execute model.
//  1 "++." len3, ready=1: issue INC,INC,OUT at pc 0,1,2 on consecutive cycles.
//    pc=3 -> done=1 next cycle. 4 cycles start-to-done.
//  2 Backpressure: "+>" with ready low for 3 cycles on INC -> instr_code=INC held.
//    pc stays 0 until ready; then MOVR.
//  3 "[+[-]]." with cell_zero=1 at pc0 -> SCAN_FWD, depth 1->2->1.
//    Exit at pc5 -> RUN at pc6, OUT issued; INC/DEC never issued.
//  4 "+[-]" with cell_zero=0 at pc3 -> SCAN_BACK to pc1 -> RUN at pc2, DEC reissued.
//    With cell_zero=1 -> pc4 -> done.
//  5 Errors: "[+" with cell_zero=1 -> err=1.
//    "+]" with cell_zero=0 -> err=2 when pc reaches 0.
//    DEPTH_W=2 with "[[[[" and cell_zero=1 -> err=3.
//    Then start -> err=0, RUN.
//  6 rst asserted mid-SCAN_FWD and while valid&&!ready -> same cycle: pc=0, IDLE,
//    valid=0, busy=0. exec_idle=0 at a bracket -> stall with no pc change.

Source files
------------

// File: rtl/bf_pkg.sv
// Shared types for the brainfuck core: opcodes, sequencer states and error codes.
package bf_pkg;

    typedef enum logic [2:0] {
        IN   = 3'b000,
        OUT  = 3'b001,
        BACK = 3'b010,
        IF   = 3'b011,
        MOVL = 3'b100,
        MOVR = 3'b101,
        DEC  = 3'b110,
        INC  = 3'b111
    } opcode_t;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RUN       = 3'd1,
        S_SCAN_FWD  = 3'd2,
        S_SCAN_BACK = 3'd3,
        S_DONE      = 3'd4,
        S_ERROR     = 3'd5
    } seq_state_t;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'd0,
        ERR_OPEN  = 2'd1,
        ERR_CLOSE = 2'd2,
        ERR_DEPTH = 2'd3
    } err_t;

    // Everything except the two brackets is handed to the execute unit.
    function automatic logic is_exec_op(input opcode_t op);
        return (op != IF) && (op != BACK);
    endfunction

endpackage

// File: rtl/bf_fetch_sequencer.sv
// Program counter and fetch FSM: issues data ops to the execute unit and
// resolves loop brackets locally with forward/backward bracket-matching scans.
module bf_fetch_sequencer
    import bf_pkg::*;
#(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned DEPTH_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [2:0]        rom_code,
    input  logic              rom_overrun,
    output logic              instr_valid,
    output logic [2:0]        instr_code,
    input  logic              instr_ready,
    input  logic              exec_idle,
    input  logic              cell_zero,
    output logic              busy,
    output logic              done,
    output logic [1:0]        err
);

    localparam logic [DEPTH_W-1:0] DEPTH_ONE = DEPTH_W'(1);

    seq_state_t          state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [DEPTH_W-1:0]  depth_q, depth_d;
    err_t                err_q, err_d;

    opcode_t             code_c;
    logic [ADDR_W-1:0]   pc_inc_c, pc_dec_c;
    logic                pc_max_c, pc_zero_c, depth_max_c, depth_one_c;

    assign code_c      = opcode_t'(rom_code);
    assign pc_inc_c    = pc_q + ADDR_W'(1);
    assign pc_dec_c    = pc_q - ADDR_W'(1);
    assign pc_max_c    = &pc_q;
    assign pc_zero_c   = (pc_q == '0);
    assign depth_max_c = &depth_q;
    assign depth_one_c = (depth_q == DEPTH_ONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            depth_q <= '0;
            err_q   <= ERR_NONE;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            depth_q <= depth_d;
            err_q   <= err_d;
        end
    end

    // Next-state and handshake decode; pc never wraps, running off the top ends the program.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        depth_d     = depth_q;
        err_d       = err_q;
        instr_valid = 1'b0;
        instr_code  = 3'b000;

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_d = S_RUN;
                    pc_d    = '0;
                    depth_d = '0;
                    err_d   = ERR_NONE;
                end
            end

            S_RUN: begin
                if (rom_overrun) begin
                    state_d = S_DONE;
                end else if (is_exec_op(code_c)) begin
                    instr_valid = 1'b1;
                    instr_code  = rom_code;
                    if (instr_ready) begin
                        if (pc_max_c) state_d = S_DONE;
                        else          pc_d    = pc_inc_c;
                    end
                end else if (exec_idle) begin
                    if (code_c == IF) begin
                        if (!cell_zero) begin
                            if (pc_max_c) state_d = S_DONE;
                            else          pc_d    = pc_inc_c;
                        end else if (pc_max_c) begin
                            state_d = S_ERROR;
                            err_d   = ERR_OPEN;
                        end else begin
                            state_d = S_SCAN_FWD;
                            pc_d    = pc_inc_c;
                            depth_d = DEPTH_ONE;
                        end
                    end else begin
                        if (cell_zero) begin
                            if (pc_max_c) state_d = S_DONE;
                            else          pc_d    = pc_inc_c;
                        end else if (pc_zero_c) begin
                            state_d = S_ERROR;
                            err_d   = ERR_CLOSE;
                        end else begin
                            state_d = S_SCAN_BACK;
                            pc_d    = pc_dec_c;
                            depth_d = DEPTH_ONE;
                        end
                    end
                end
            end

            S_SCAN_FWD: begin
                if (rom_overrun) begin
                    state_d = S_ERROR;
                    err_d   = ERR_OPEN;
                end else if ((code_c == IF) && depth_max_c) begin
                    state_d = S_ERROR;
                    err_d   = ERR_DEPTH;
                end else if ((code_c == BACK) && depth_one_c) begin
                    if (pc_max_c) state_d = S_DONE;
                    else begin
                        state_d = S_RUN;
                        pc_d    = pc_inc_c;
                    end
                end else if (pc_max_c) begin
                    state_d = S_ERROR;
                    err_d   = ERR_OPEN;
                end else begin
                    pc_d = pc_inc_c;
                    if (code_c == IF)   depth_d = depth_q + DEPTH_ONE;
                    if (code_c == BACK) depth_d = depth_q - DEPTH_ONE;
                end
            end

            S_SCAN_BACK: begin
                if ((code_c == IF) && depth_one_c) begin
                    state_d = S_RUN;
                    pc_d    = pc_inc_c;
                end else if ((code_c == BACK) && depth_max_c) begin
                    state_d = S_ERROR;
                    err_d   = ERR_DEPTH;
                end else if (pc_zero_c) begin
                    state_d = S_ERROR;
                    err_d   = ERR_CLOSE;
                end else begin
                    pc_d = pc_dec_c;
                    if (code_c == BACK) depth_d = depth_q + DEPTH_ONE;
                    if (code_c == IF)   depth_d = depth_q - DEPTH_ONE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign rom_addr = pc_q;
    assign busy     = (state_q == S_RUN) || (state_q == S_SCAN_FWD) || (state_q == S_SCAN_BACK);
    assign done     = (state_q == S_DONE);
    assign err      = err_q;

endmodule

// File: tb/tb_bf_fetch_sequencer.sv
// Directed bench for bf_fetch_sequencer: stub ROM, scripted execute-unit inputs,
// hand-computed cycle-by-cycle expectations.
module tb_bf_fetch_sequencer;
    import bf_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        instr_ready = 1'b1;
    logic        exec_idle = 1'b1;
    logic        cell_zero = 1'b0;

    logic [9:0]  addr0, addr1;
    logic [2:0]  code0, code1, icode0, icode1;
    logic        ovr0, ovr1, v0, v1, busy0, busy1, done0, done1;
    logic [1:0]  err0, err1;

    logic [2:0]  rom [0:15];
    int unsigned rom_len = 0;
    logic [2:0]  issued [$];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    function automatic logic [2:0] rom_rd(input logic [9:0] a);
        if (a < 10'd16) return rom[a[3:0]];
        return 3'b000;
    endfunction

    assign code0 = rom_rd(addr0);
    assign code1 = rom_rd(addr1);
    assign ovr0  = (32'(addr0) >= rom_len);
    assign ovr1  = (32'(addr1) >= rom_len);

    bf_fetch_sequencer #(.ADDR_W(10), .DEPTH_W(8)) dut (
        .clk(clk), .rst(rst), .start(start),
        .rom_addr(addr0), .rom_code(code0), .rom_overrun(ovr0),
        .instr_valid(v0), .instr_code(icode0), .instr_ready(instr_ready),
        .exec_idle(exec_idle), .cell_zero(cell_zero),
        .busy(busy0), .done(done0), .err(err0)
    );

    bf_fetch_sequencer #(.ADDR_W(10), .DEPTH_W(2)) dut_d2 (
        .clk(clk), .rst(rst), .start(start),
        .rom_addr(addr1), .rom_code(code1), .rom_overrun(ovr1),
        .instr_valid(v1), .instr_code(icode1), .instr_ready(instr_ready),
        .exec_idle(exec_idle), .cell_zero(cell_zero),
        .busy(busy1), .done(done1), .err(err1)
    );

    // Record every op the execute unit accepts (inputs are stable around negedge).
    always @(negedge clk) begin
        if (!rst && v0 && instr_ready) issued.push_back(icode0);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic load(input string s);
        for (int i = 0; i < 16; i++) rom[i] = IN;
        for (int i = 0; i < s.len(); i++) begin
            case (s[i])
                "+": rom[i] = INC;
                "-": rom[i] = DEC;
                ">": rom[i] = MOVR;
                "<": rom[i] = MOVL;
                "[": rom[i] = IF;
                "]": rom[i] = BACK;
                ".": rom[i] = OUT;
                default: rom[i] = IN;
            endcase
        end
        rom_len = s.len();
        issued.delete();
    endtask

    task automatic kick();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rom[i] = IN;
        cyc(2);
        chk("rst_pc",    32'(addr0), 32'd0);
        chk("rst_valid", 32'(v0),    32'd0);
        chk("rst_busy",  32'(busy0), 32'd0);
        chk("rst_done",  32'(done0), 32'd0);
        chk("rst_err",   32'(err0),  32'd0);
        rst = 1'b0;
        cyc();
        chk("idle_busy", 32'(busy0), 32'd0);

        // 1: straight-line program, ready always high
        load("++.");
        kick();
        chk("t1_busy", 32'(busy0), 32'd1);
        chk("t1_pc0",  32'(addr0), 32'd0);
        chk("t1_v0",   32'(v0),    32'd1);
        chk("t1_c0",   32'(icode0), 32'(INC));
        cyc();
        chk("t1_pc1",  32'(addr0), 32'd1);
        chk("t1_c1",   32'(icode0), 32'(INC));
        cyc();
        chk("t1_pc2",  32'(addr0), 32'd2);
        chk("t1_c2",   32'(icode0), 32'(OUT));
        cyc();
        chk("t1_pc3",  32'(addr0), 32'd3);
        chk("t1_v3",   32'(v0),    32'd0);
        chk("t1_nd3",  32'(done0), 32'd0);
        cyc();
        chk("t1_done", 32'(done0), 32'd1);
        chk("t1_nbsy", 32'(busy0), 32'd0);
        chk("t1_n",    32'(issued.size()), 32'd3);
        if (issued.size() == 3) begin
            chk("t1_i0", 32'(issued[0]), 32'(INC));
            chk("t1_i1", 32'(issued[1]), 32'(INC));
            chk("t1_i2", 32'(issued[2]), 32'(OUT));
        end

        // 2: backpressure holds INC and pc
        load("+>");
        instr_ready = 1'b0;
        kick();
        for (int k = 0; k < 3; k++) begin
            chk("t2_hold_v",  32'(v0),     32'd1);
            chk("t2_hold_c",  32'(icode0), 32'(INC));
            chk("t2_hold_pc", 32'(addr0),  32'd0);
            if (k < 2) cyc();
        end
        instr_ready = 1'b1;
        cyc();
        chk("t2_pc1", 32'(addr0),  32'd1);
        chk("t2_c1",  32'(icode0), 32'(MOVR));
        cyc(2);
        chk("t2_done", 32'(done0), 32'd1);
        chk("t2_n",    32'(issued.size()), 32'd2);

        // 3: forward scan over nested loop
        load("[+[-]].");
        cell_zero = 1'b1;
        kick();
        chk("t3_pc0", 32'(addr0), 32'd0);
        chk("t3_v0",  32'(v0),    32'd0);
        cyc();
        chk("t3_pc1",  32'(addr0), 32'd1);
        chk("t3_busy", 32'(busy0), 32'd1);
        cyc(2);
        chk("t3_pc3", 32'(addr0), 32'd3);
        cyc(2);
        chk("t3_pc5", 32'(addr0), 32'd5);
        chk("t3_v5",  32'(v0),    32'd0);
        cyc();
        chk("t3_pc6", 32'(addr0),  32'd6);
        chk("t3_v6",  32'(v0),     32'd1);
        chk("t3_c6",  32'(icode0), 32'(OUT));
        cyc(2);
        chk("t3_done", 32'(done0), 32'd1);
        chk("t3_n",    32'(issued.size()), 32'd1);
        if (issued.size() == 1) chk("t3_i0", 32'(issued[0]), 32'(OUT));

        // 4: backward scan then loop exit
        load("+[-]");
        cell_zero = 1'b0;
        kick();
        chk("t4_c0", 32'(icode0), 32'(INC));
        cyc(2);
        chk("t4_pc2", 32'(addr0),  32'd2);
        chk("t4_c2",  32'(icode0), 32'(DEC));
        cyc();
        chk("t4_pc3", 32'(addr0), 32'd3);
        chk("t4_v3",  32'(v0),    32'd0);
        cyc();
        chk("t4_sb_pc2",  32'(addr0), 32'd2);
        chk("t4_sb_v",    32'(v0),    32'd0);
        chk("t4_sb_busy", 32'(busy0), 32'd1);
        cyc();
        chk("t4_sb_pc1", 32'(addr0), 32'd1);
        cyc();
        chk("t4_re_pc2", 32'(addr0),  32'd2);
        chk("t4_re_v",   32'(v0),     32'd1);
        chk("t4_re_c",   32'(icode0), 32'(DEC));
        cell_zero = 1'b1;
        cyc(2);
        chk("t4_pc4", 32'(addr0), 32'd4);
        cyc();
        chk("t4_done", 32'(done0), 32'd1);
        chk("t4_n",    32'(issued.size()), 32'd3);
        if (issued.size() == 3) chk("t4_i2", 32'(issued[2]), 32'(DEC));

        // 5a: unmatched '['
        load("[+");
        cell_zero = 1'b1;
        kick();
        cyc(2);
        chk("t5a_err0", 32'(err0), 32'd0);
        cyc();
        chk("t5a_err",  32'(err0),  32'd1);
        chk("t5a_busy", 32'(busy0), 32'd0);
        chk("t5a_done", 32'(done0), 32'd0);

        // 5b: unmatched ']'
        load("+]");
        cell_zero = 1'b0;
        kick();
        cyc(2);
        chk("t5b_pc0",  32'(addr0), 32'd0);
        chk("t5b_busy", 32'(busy0), 32'd1);
        cyc();
        chk("t5b_err", 32'(err0),  32'd2);
        chk("t5b_pc",  32'(addr0), 32'd0);

        // 5c: depth overflow on the narrow-depth instance
        load("[[[[");
        cell_zero = 1'b1;
        kick();
        cyc(3);
        chk("t5c_d2_pre", 32'(err1), 32'd0);
        cyc();
        chk("t5c_d2_err", 32'(err1), 32'd3);
        chk("t5c_w_busy", 32'(busy0), 32'd1);
        cyc();
        chk("t5c_w_err", 32'(err0), 32'd1);
        kick();
        chk("t5c_clr0",  32'(err0),  32'd0);
        chk("t5c_clr1",  32'(err1),  32'd0);
        chk("t5c_run",   32'(busy1), 32'd1);

        // 6a: reset in the middle of a forward scan
        cyc(2);
        chk("t6a_pc2",  32'(addr0), 32'd2);
        rst = 1'b1;
        #1;
        chk("t6a_pc",    32'(addr0), 32'd0);
        chk("t6a_busy",  32'(busy0), 32'd0);
        chk("t6a_valid", 32'(v0),    32'd0);
        cyc();
        rst = 1'b0;

        // 6b: reset during a stalled handshake
        load("+>");
        cell_zero = 1'b0;
        instr_ready = 1'b0;
        kick();
        chk("t6b_v_pre", 32'(v0), 32'd1);
        rst = 1'b1;
        #1;
        chk("t6b_valid", 32'(v0),    32'd0);
        chk("t6b_pc",    32'(addr0), 32'd0);
        chk("t6b_busy",  32'(busy0), 32'd0);
        cyc();
        rst = 1'b0;
        instr_ready = 1'b1;

        // 6c: bracket waits for exec_idle; start ignored while busy
        load("+[-]");
        kick();
        exec_idle = 1'b0;
        cyc();
        chk("t6c_pc1", 32'(addr0), 32'd1);
        chk("t6c_v",   32'(v0),    32'd0);
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("t6c_stall_pc", 32'(addr0), 32'd1);
        cyc();
        chk("t6c_stall2", 32'(addr0), 32'd1);
        exec_idle = 1'b1;
        cyc();
        chk("t6c_pc2", 32'(addr0),  32'd2);
        chk("t6c_c2",  32'(icode0), 32'(DEC));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
